// File: rtl/prog_loader.sv
// Boot-time program loader: accepts a framed byte stream (HDR, LEN,
// LEN payload bytes, CSUM) and writes the payload to instruction memory
// from address 0, holding the core in reset until a frame's checksum
// matches.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_data/in_valid      incoming byte stream
//   in_ready              loader can accept a byte (low only in RUN)
//   mem_we/addr/wdata     registered one-cycle write to instruction memory
//   core_rst              core reset, high until a good frame is loaded
//   done                  load complete, core running
//   err/err_code          last frame aborted: 1 csum, 2 zero len, 3 timeout
module prog_loader #(
    parameter int         ADDR_W  = 8,
    parameter int         TIMEOUT = 1000,
    parameter logic [7:0] HDR     = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_RUN
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [7:0]        len;
    logic [7:0]        sum;
    logic [ADDR_W-1:0] addr;
    logic [TW-1:0]     tcnt;
    logic              acc;
    logic              active;
    logic              tmo;
    logic              last;

    assign in_ready = (state != S_RUN);
    assign acc      = in_valid && in_ready;
    assign active   = (state == S_LEN) || (state == S_DATA) ||
                      (state == S_CSUM);
    // tcnt counts idle cycles already elapsed; an idle edge with
    // tcnt == TIMEOUT-1 is the TIMEOUT-th idle cycle. An accepted byte
    // on that edge suppresses the timeout.
    assign tmo      = active && !acc && (tcnt == TW'(TIMEOUT - 1));
    // len is nonzero whenever DATA is entered, so len-1 cannot wrap.
    assign last     = (addr == ADDR_W'(len - 8'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (acc && in_data == HDR) begin
                    state_n = S_LEN;
                end
            end
            S_LEN: begin
                if (acc) begin
                    state_n = (in_data == 8'd0) ? S_IDLE : S_DATA;
                end else if (tmo) begin
                    state_n = S_IDLE;
                end
            end
            S_DATA: begin
                if (acc) begin
                    if (last) begin
                        state_n = S_CSUM;
                    end
                end else if (tmo) begin
                    state_n = S_IDLE;
                end
            end
            S_CSUM: begin
                if (acc) begin
                    state_n = (in_data == sum) ? S_RUN : S_IDLE;
                end else if (tmo) begin
                    state_n = S_IDLE;
                end
            end
            S_RUN: begin
                state_n = S_RUN;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len       <= '0;
            sum       <= '0;
            addr      <= '0;
            tcnt      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            core_rst  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            mem_we <= 1'b0;

            if (active && !acc && !tmo) begin
                tcnt <= tcnt + TW'(1);
            end else begin
                tcnt <= '0;
            end

            if (tmo) begin
                err      <= 1'b1;
                err_code <= 2'd3;
            end

            if (acc) begin
                unique case (state)
                    S_IDLE: begin
                        if (in_data == HDR) begin
                            err      <= 1'b0;
                            err_code <= 2'd0;
                            sum      <= '0;
                            addr     <= '0;
                        end
                    end
                    S_LEN: begin
                        len <= in_data;
                        if (in_data == 8'd0) begin
                            err      <= 1'b1;
                            err_code <= 2'd2;
                        end
                    end
                    S_DATA: begin
                        sum       <= sum + in_data;
                        mem_we    <= 1'b1;
                        mem_addr  <= addr;
                        mem_wdata <= in_data;
                        addr      <= addr + ADDR_W'(1);
                    end
                    S_CSUM: begin
                        if (in_data == sum) begin
                            core_rst <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            err      <= 1'b1;
                            err_code <= 2'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
